// File: rtl/uart_pkg.sv
// Shared UART constants and the tx buffer sequencer state encoding.
// Encoding is fixed so waveforms read the same across the uart blocks.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLKS_PER_BIT = 5208;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    ISSUE     = ST_ISSUE,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP
  } tx_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock circular FIFO, show-ahead read (rd_data is the head entry), 1-cycle write-to-visible.
// Writes while full and reads while empty are ignored; the caller owns any error reporting.
module fifo_sync
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]  DEPTH = CNT_W'(1) << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (cnt == DEPTH);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO draining into uart_tx; first tx_dv one cycle after the byte is visible, 2 idle cycles between tx_done and next tx_dv.
// Producers see full/overflow only; no start is issued while the transmitter reports tx_active.
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = uart_pkg::DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_dv,
  output logic [DATA_W-1:0]     tx_byte,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic                  busy
);

  import uart_pkg::*;

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic              pop;
  logic [DATA_W-1:0] head;

  fifo_sync #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // tx_active guard also covers a frame left running across our reset.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_active) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_nxt = GAP;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
      overflow <= 1'b0;
    end else begin
      tx_dv    <= pop;
      overflow <= wr_en && full;
      if (pop) tx_byte <= head;
    end
  end

  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: behavioural transmitter (4 clocks/bit, 10-bit frame) plus a queue-based scoreboard.
module tb_uart_tx_buffer;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_buffer #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: has no reset, like the real uart_tx; stall freezes it mid-frame.
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  int   m_cnt    = 0;
  logic stall    = 1'b0;
  logic stray    = 1'b0;
  assign tx_active = m_active;
  assign tx_done   = m_done | stray;

  always @(posedge clock) begin
    m_done <= 1'b0;
    if (!m_active) begin
      if (tx_dv) begin
        m_active <= 1'b1;
        m_cnt    <= FRAME - 1;
      end
    end else if (!stall) begin
      if (m_cnt == 0) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Scoreboard: queue of accepted bytes, occupancy from pushes minus observed starts.
  logic       s_wr = 1'b0;
  logic [7:0] s_dat = 8'h00;
  always @(posedge clock) begin
    s_wr  <= wr_en && reset;
    s_dat <= wr_data;
  end

  logic [7:0] exp_q[$];
  int         occ = 0;
  int         cyc = 0;
  int         dv_cnt = 0;
  int         done_cyc = 0;
  logic       done_pend = 1'b0;
  logic       done_d = 1'b0;
  logic       gap_en = 1'b0;
  logic       iss_vld = 1'b0;
  logic [7:0] iss_byte = 8'h00;

  always @(negedge clock) begin
    logic [8:0] exp_b;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      occ       = 0;
      done_pend = 1'b0;
      iss_vld   = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_dv", 32'(tx_dv), 0);
    end else begin
      chk("overflow", 32'(overflow), 32'(s_wr && occ == 16));
      if (s_wr && occ < 16) begin
        exp_q.push_back(s_dat);
        occ++;
      end
      if (tx_done && !done_d) begin
        done_cyc  = cyc;
        done_pend = 1'b1;
        if (iss_vld) chk("tx_byte_hold", 32'(tx_byte), 32'(iss_byte));
      end
      if (tx_dv) begin
        chk("dv_while_active", 32'(tx_active), 0);
        exp_b = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        chk("tx_byte_order", 32'({1'b0, tx_byte}), 32'(exp_b));
        if (occ > 0) occ--;
        dv_cnt++;
        iss_byte = tx_byte;
        iss_vld  = 1'b1;
        // Idle cycles strictly between the tx_done cycle and the tx_dv cycle.
        if (gap_en && done_pend) chk("dv_gap", 32'(cyc - done_cyc - 1), 2);
        done_pend = 1'b0;
      end
      chk("count", 32'(count), 32'(occ));
      chk("empty", 32'(empty), 32'(occ == 0));
      chk("full", 32'(full), 32'(occ == 16));
    end
    done_d = tx_done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (empty && !busy && !tx_active && !tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 1);
  endtask

  initial begin
    int  base;
    bit  seen;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_tx_dv", 32'(tx_dv), 0);
    chk("reset_tx_byte", 32'(tx_byte), 0);
    chk("reset_busy", 32'(busy), 0);
    tick();
    reset = 1'b1;

    // Single byte latency
    tick();
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    @(negedge clock);
    chk("single_no_early_dv", 32'(tx_dv), 0);
    chk("single_count", 32'(count), 1);
    @(negedge clock);
    chk("single_dv", 32'(tx_dv), 1);
    chk("single_byte", 32'(tx_byte), 8'h41);
    chk("single_busy", 32'(busy), 1);
    wait_idle(200);
    chk("single_busy_fall", 32'(busy), 0);
    chk("single_dv_cnt", 32'(dv_cnt), 1);

    // Burst of 16 back-to-back writes
    base = dv_cnt;
    done_pend = 1'b0;
    gap_en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    @(negedge clock);
    chk("burst_count", 32'(count), 15);
    wait_idle(16 * (FRAME + 10) + 100);
    chk("burst_dv_cnt", 32'(dv_cnt - base), 16);
    gap_en = 1'b0;

    // Overflow with the transmitter held busy
    base = dv_cnt;
    stall = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h10;
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
      tick();
    end
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    @(negedge clock);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_full", 32'(full), 1);
    @(negedge clock);
    chk("ovf_one_cycle", 32'(overflow), 0);
    stall = 1'b0;
    wait_idle(17 * (FRAME + 10) + 100);
    chk("ovf_dv_cnt", 32'(dv_cnt - base), 17);
    chk("ovf_last_byte", 32'(iss_byte), 8'h8F);

    // Push on the same edge IDLE pops, with one entry queued
    stall = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h21;
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    wr_en = 1'b1; wr_data = 8'h22;
    tick();
    wr_en = 1'b0;
    stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pp_done_timeout", 32'(seen), 1);
    @(posedge clock);
    @(posedge clock);
    #1;
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    @(negedge clock);
    chk("pp_dv", 32'(tx_dv), 1);
    chk("pp_byte", 32'(tx_byte), 8'h22);
    chk("pp_count", 32'(count), 1);
    wait_idle(3 * (FRAME + 10));
    chk("pp_last_byte", 32'(iss_byte), 8'h55);

    // Reset during the second of four frames
    base = dv_cnt;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (dv_cnt == base + 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_timeout", 32'(seen), 1);
    repeat (10) tick();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_dv", 32'(tx_dv), 0);
    chk("rst_mid_empty", 32'(empty), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    tick();
    reset = 1'b1;
    wr_en = 1'b1; wr_data = 8'h7E;
    tick();
    wr_en = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_guard_dv", 32'(tx_dv), 0);
    wait_idle(4 * (FRAME + 10));
    chk("rst_dv_cnt", 32'(dv_cnt - base), 3);
    chk("rst_last_byte", 32'(iss_byte), 8'h7E);

    // Stray tx_done while idle and empty
    base = dv_cnt;
    tick();
    stray = 1'b1;
    repeat (4) tick();
    stray = 1'b0;
    @(negedge clock);
    chk("stray_dv", 32'(tx_dv), 0);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_dv_cnt", 32'(dv_cnt - base), 0);
    tick();
    wr_en = 1'b1; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    repeat (2) @(negedge clock);
    chk("stray_then_dv", 32'(tx_dv), 1);
    wait_idle(2 * (FRAME + 10));

    // Random writes with random gaps, overflowing at times
    tick();
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      tick();
      wr_en = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle(5000);
    chk("rand_queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
